// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI input path: message record,
// system status codes, UART state encoding and the data-length lookup.
package midi_pkg;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] len;
    } msg_t;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] TUNE_REQ    = 8'hF6;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    // Data bytes that follow a status byte; 0 means the status carries no running message.
    function automatic logic [1:0] expected_data_len(input logic [7:0] status);
        logic [1:0] n;
        n = 2'd0;
        case (status[7:4])
            4'hC, 4'hD:                   n = 2'd1;
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
            4'hF: begin
                case (status[3:0])
                    4'h1, 4'h3: n = 2'd1;
                    4'h2:       n = 2'd2;
                    default:    n = 2'd0;
                endcase
            end
            default:                      n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// Oversampled 8N1 receiver: 2-flop synchroniser, start-bit validation at
// mid-bit, LSB-first data capture and stop-bit check.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       midi_rx_i,
    output logic [7:0] byte_o,
    output logic       byte_strobe_o,
    output logic       framing_err_o
);

    localparam int            CW   = $clog2(OVERSAMPLE + 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE);
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TWO  = {{(CW-2){1'b0}}, 2'b10};

    logic          sync1_q, sync2_q, prev_q;
    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          strobe_q, strobe_d;
    logic          fe_q, fe_d;
    logic          fall_s;

    assign fall_s        = prev_q & ~sync2_q;
    assign byte_o        = shift_q;
    assign byte_strobe_o = strobe_q;
    assign framing_err_o = fe_q;

    // Synchroniser, edge history and FSM state registers.
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            state_q  <= U_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            strobe_q <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            sync1_q  <= midi_rx_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            strobe_q <= strobe_d;
            fe_q     <= fe_d;
        end
    end

    // Bit timing and sampling; outputs are registered, so the counter starts
    // one tick ahead to land the strobe on the nominal stop-sample tick.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        strobe_d = 1'b0;
        fe_d     = 1'b0;
        case (state_q)
            U_IDLE: begin
                if (fall_s) begin
                    state_d = U_START;
                    cnt_d   = TWO;
                end else begin
                    cnt_d   = '0;
                end
            end
            U_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = ONE;
                    bit_d = 3'd0;
                    if (!sync2_q) begin
                        state_d = U_DATA;
                    end else begin
                        state_d = U_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            U_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = ONE;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            U_STOP: begin
                if (cnt_q == FULL) begin
                    state_d = U_IDLE;
                    cnt_d   = '0;
                    if (sync2_q) begin
                        strobe_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = U_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/midi_msg_rx.sv
// MIDI message assembler: running status, realtime pass-through, SysEx
// skipping and channel filtering, feeding a first-word-fall-through FIFO.
module midi_msg_rx
    import midi_pkg::*;
#(
    parameter int          OVERSAMPLE   = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       midi_rx_i,
    input  logic       msg_ready_i,
    output logic       msg_valid_o,
    output logic [7:0] msg_status_o,
    output logic [7:0] msg_data1_o,
    output logic [7:0] msg_data2_o,
    output logic [1:0] msg_len_o,
    output logic       overflow_o,
    output logic       framing_err_o
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0] rx_byte_s;
    logic       rx_strobe_s;
    logic       rx_fe_s;

    midi_uart_rx #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_uart (
        .baud_clk     (baud_clk),
        .rst          (rst),
        .midi_rx_i    (midi_rx_i),
        .byte_o       (rx_byte_s),
        .byte_strobe_o(rx_strobe_s),
        .framing_err_o(rx_fe_s)
    );

    logic [7:0] rs_q, rs_d;
    logic       rs_vld_q, rs_vld_d;
    logic [1:0] dcnt_q, dcnt_d;
    logic [7:0] d1_q, d1_d;
    logic       sysex_q, sysex_d;
    logic       emit_q, emit_d;
    msg_t       emit_msg_q, emit_msg_d;
    logic [1:0] exp_len_s;
    logic       chan_ok_s;

    assign exp_len_s = expected_data_len(rs_q);
    assign chan_ok_s = (rs_q < SYSEX_START) ? CHANNEL_MASK[rs_q[3:0]] : 1'b1;

    // Parser state and the registered emit handed to the FIFO.
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            rs_q       <= 8'h00;
            rs_vld_q   <= 1'b0;
            dcnt_q     <= 2'd0;
            d1_q       <= 8'h00;
            sysex_q    <= 1'b0;
            emit_q     <= 1'b0;
            emit_msg_q <= '0;
        end else begin
            rs_q       <= rs_d;
            rs_vld_q   <= rs_vld_d;
            dcnt_q     <= dcnt_d;
            d1_q       <= d1_d;
            sysex_q    <= sysex_d;
            emit_q     <= emit_d;
            emit_msg_q <= emit_msg_d;
        end
    end

    // Byte classification; statuses without data (F0, F4-F7) leave no running status.
    always_comb begin
        rs_d       = rs_q;
        rs_vld_d   = rs_vld_q;
        dcnt_d     = dcnt_q;
        d1_d       = d1_q;
        sysex_d    = sysex_q;
        emit_d     = 1'b0;
        emit_msg_d = emit_msg_q;
        if (rx_fe_s) begin
            rs_vld_d = 1'b0;
            dcnt_d   = 2'd0;
        end else if (rx_strobe_s) begin
            if (rx_byte_s >= RT_MIN) begin
                emit_d     = 1'b1;
                emit_msg_d = '{status: rx_byte_s, d1: 8'h00, d2: 8'h00, len: 2'd1};
            end else if (rx_byte_s[7]) begin
                sysex_d  = (rx_byte_s == SYSEX_START);
                dcnt_d   = 2'd0;
                rs_d     = rx_byte_s;
                rs_vld_d = (expected_data_len(rx_byte_s) != 2'd0);
                if (rx_byte_s == TUNE_REQ) begin
                    emit_d     = 1'b1;
                    emit_msg_d = '{status: TUNE_REQ, d1: 8'h00, d2: 8'h00, len: 2'd1};
                end else begin
                    emit_d = 1'b0;
                end
            end else if (sysex_q || !rs_vld_q) begin
                emit_d = 1'b0;
            end else if ((dcnt_q == 2'd0) && (exp_len_s == 2'd2)) begin
                d1_d   = rx_byte_s;
                dcnt_d = 2'd1;
            end else begin
                emit_d = chan_ok_s;
                if (dcnt_q == 2'd0) begin
                    emit_msg_d = '{status: rs_q, d1: rx_byte_s, d2: 8'h00, len: 2'd2};
                end else begin
                    emit_msg_d = '{status: rs_q, d1: d1_q, d2: rx_byte_s, len: 2'd3};
                end
                dcnt_d   = 2'd0;
                rs_vld_d = (rs_q < SYSEX_START);
            end
        end else begin
            emit_d = 1'b0;
        end
    end

    logic [AW:0] wr_q, rd_q;
    msg_t        mem_q [FIFO_DEPTH];
    msg_t        head_s;
    logic        full_s, empty_s, pop_s, push_s;
    logic        overflow_q, framing_q;

    assign empty_s = (wr_q == rd_q);
    assign full_s  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_s   = !empty_s && msg_ready_i;
    assign push_s  = emit_q && (!full_s || pop_s);

    // FIFO pointers and one-cycle status pulses.
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            framing_q  <= 1'b0;
        end else begin
            wr_q       <= push_s ? (wr_q + PTR_ONE) : wr_q;
            rd_q       <= pop_s ? (rd_q + PTR_ONE) : rd_q;
            overflow_q <= emit_q && full_s && !pop_s;
            framing_q  <= rx_fe_s;
        end
    end

    // FIFO storage.
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_q[AW-1:0]] <= emit_msg_q;
        end
    end

    // Head of queue, forced to zero while empty.
    always_comb begin
        if (empty_s) begin
            head_s = '0;
        end else begin
            head_s = mem_q[rd_q[AW-1:0]];
        end
    end

    assign msg_valid_o   = !empty_s;
    assign msg_status_o  = head_s.status;
    assign msg_data1_o   = head_s.d1;
    assign msg_data2_o   = head_s.d2;
    assign msg_len_o     = head_s.len;
    assign overflow_o    = overflow_q;
    assign framing_err_o = framing_q;

endmodule

// File: tb/tb_midi_msg_rx.sv
// Self-checking bench: two instances (all channels / channel 0 only) share
// one serial line and are compared against a queue-based message model.
module tb_midi_msg_rx;

    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic baud_clk = 1'b0;
    logic rst;
    logic midi_rx;
    logic msg_ready;

    logic       v0, v1, ovf0, ovf1, fe0, fe1;
    logic [7:0] st0, st1, da0, da1, db0, db1;
    logic [1:0] ln0, ln1;

    always #5 baud_clk = ~baud_clk;

    midi_msg_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .CHANNEL_MASK(16'hFFFF)) u_dut_all (
        .baud_clk(baud_clk), .rst(rst), .midi_rx_i(midi_rx), .msg_ready_i(msg_ready),
        .msg_valid_o(v0), .msg_status_o(st0), .msg_data1_o(da0), .msg_data2_o(db0),
        .msg_len_o(ln0), .overflow_o(ovf0), .framing_err_o(fe0)
    );

    midi_msg_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .CHANNEL_MASK(16'h0001)) u_dut_ch0 (
        .baud_clk(baud_clk), .rst(rst), .midi_rx_i(midi_rx), .msg_ready_i(msg_ready),
        .msg_valid_o(v1), .msg_status_o(st1), .msg_data1_o(da1), .msg_data2_o(db1),
        .msg_len_o(ln1), .overflow_o(ovf1), .framing_err_o(fe1)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [25:0] obs_q0[$], obs_q1[$], exp_q0[$], exp_q1[$];
    int ovf_cnt[2] = '{0, 0};
    int fe_cnt[2]  = '{0, 0};
    int exp_ovf[2] = '{0, 0};
    int exp_fe[2]  = '{0, 0};

    // Reference model state: running status, collected data bytes, sysex flag.
    logic [7:0]  m_rs[2];
    bit          m_has[2]   = '{1'b0, 1'b0};
    int          m_n[2]     = '{0, 0};
    logic [7:0]  m_buf[2][2];
    bit          m_sysex[2] = '{1'b0, 1'b0};
    int          m_pend[2]  = '{0, 0};
    bit          m_stall    = 1'b0;
    logic [15:0] m_mask[2]  = '{16'hFFFF, 16'h0001};

    // Collect accepted messages and status pulses away from the active edge.
    always @(negedge baud_clk) begin
        if (rst) begin
            if (v0 && msg_ready) obs_q0.push_back({st0, da0, db0, ln0});
            if (v1 && msg_ready) obs_q1.push_back({st1, da1, db1, ln1});
            if (ovf0) ovf_cnt[0]++;
            if (ovf1) ovf_cnt[1]++;
            if (fe0) fe_cnt[0]++;
            if (fe1) fe_cnt[1]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_emit(input int k, input logic [25:0] m);
        if (m_stall && m_pend[k] >= DEPTH) begin
            exp_ovf[k]++;
        end else begin
            if (k == 0) exp_q0.push_back(m);
            else        exp_q1.push_back(m);
            if (m_stall) m_pend[k]++;
        end
    endtask

    task automatic m_byte(input int k, input logic [7:0] b);
        int need;
        if (b >= 8'hF8) begin
            m_emit(k, {b, 16'h0000, 2'd1});
        end else if (b[7]) begin
            m_sysex[k] = (b == 8'hF0);
            m_n[k]     = 0;
            m_has[k]   = (b < 8'hF0) || (b == 8'hF1) || (b == 8'hF2) || (b == 8'hF3);
            m_rs[k]    = b;
            if (b == 8'hF6) m_emit(k, {b, 16'h0000, 2'd1});
        end else if (!m_sysex[k] && m_has[k]) begin
            need = ((m_rs[k] >= 8'hC0 && m_rs[k] < 8'hE0) || m_rs[k] == 8'hF1 || m_rs[k] == 8'hF3) ? 1 : 2;
            m_buf[k][m_n[k]] = b;
            m_n[k]++;
            if (m_n[k] == need) begin
                if (m_rs[k] >= 8'hF0 || m_mask[k][m_rs[k][3:0]])
                    m_emit(k, {m_rs[k], m_buf[k][0], (need == 2) ? m_buf[k][1] : 8'h00, 2'(need + 1)});
                m_n[k] = 0;
                if (m_rs[k] >= 8'hF0) m_has[k] = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v);
        midi_rx = v;
        repeat (OS) @(posedge baud_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(b[i]);
        drive(stop_ok);
        midi_rx = 1'b1;
        repeat (2 * OS) @(posedge baud_clk);
        #1;
        if (stop_ok) begin
            m_byte(0, b);
            m_byte(1, b);
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_has[k] = 1'b0;
                m_n[k]   = 0;
                exp_fe[k]++;
            end
        end
    endtask

    task automatic check_queues(input string tag);
        chk({tag, " count0"}, obs_q0.size(), exp_q0.size());
        while (obs_q0.size() > 0 && exp_q0.size() > 0)
            chk({tag, " msg0"}, {6'h00, obs_q0.pop_front()}, {6'h00, exp_q0.pop_front()});
        chk({tag, " count1"}, obs_q1.size(), exp_q1.size());
        while (obs_q1.size() > 0 && exp_q1.size() > 0)
            chk({tag, " msg1"}, {6'h00, obs_q1.pop_front()}, {6'h00, exp_q1.pop_front()});
        obs_q0.delete(); exp_q0.delete(); obs_q1.delete(); exp_q1.delete();
        for (int k = 0; k < 2; k++) begin
            chk({tag, " overflow"}, ovf_cnt[k], exp_ovf[k]);
            chk({tag, " framing"}, fe_cnt[k], exp_fe[k]);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " outs0"}, {12'h000, v0, st0, da0, db0, ln0, ovf0, fe0}, 32'h0);
        chk({tag, " outs1"}, {12'h000, v1, st1, da1, db1, ln1, ovf1, fe1}, 32'h0);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        rst = 1'b0; midi_rx = 1'b1; msg_ready = 1'b1;
        repeat (5) @(posedge baud_clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        repeat (OS) @(posedge baud_clk);
        #1;

        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1); send(8'h3E, 1'b1); send(8'h40, 1'b1);
        check_queues("running_status");
        send(8'hC5, 1'b1); send(8'h07, 1'b1); send(8'h09, 1'b1);
        check_queues("program_change");
        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'hF8, 1'b1); send(8'h64, 1'b1);
        check_queues("realtime_interleave");
        send(8'hF0, 1'b1); send(8'h43, 1'b1); send(8'h12, 1'b1); send(8'hF7, 1'b1); send(8'h3C, 1'b1);
        check_queues("sysex_skip");
        send(8'h91, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
        send(8'h80, 1'b1); send(8'h3C, 1'b1); send(8'h00, 1'b1);
        check_queues("channel_filter");

        msg_ready = 1'b0; m_stall = 1'b1; m_pend = '{0, 0};
        for (int i = 0; i < 5; i++) send(8'hF8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall head0", {15'h0, v0, st0, da0, db0, ln0}, {15'h0, 1'b1, 8'hF8, 16'h0000, 2'd1});
            chk("stall head1", {15'h0, v1, st1, da1, db1, ln1}, {15'h0, 1'b1, 8'hF8, 16'h0000, 2'd1});
            @(posedge baud_clk);
            #1;
        end
        msg_ready = 1'b1;
        repeat (10) @(posedge baud_clk);
        #1;
        m_stall = 1'b0;
        check_queues("overflow");

        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b0); send(8'h40, 1'b1);
        send(8'h80, 1'b1); send(8'h3C, 1'b1); send(8'h00, 1'b1);
        check_queues("framing");

        send(8'h90, 1'b1); send(8'h3C, 1'b1);
        rst = 1'b0;
        repeat (3) @(posedge baud_clk);
        #1;
        check_zero("mid_reset");
        for (int k = 0; k < 2; k++) begin
            m_has[k] = 1'b0; m_n[k] = 0; m_sysex[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (OS) @(posedge baud_clk);
        #1;
        send(8'h64, 1'b1); send(8'hB2, 1'b1); send(8'h07, 1'b1); send(8'h7F, 1'b1);
        send(8'hF2, 1'b1); send(8'h10, 1'b1); send(8'h20, 1'b1); send(8'h30, 1'b1);
        check_queues("after_reset");

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      b = 8'($urandom_range(0, 127));
            else if (r < 70) b = 8'($urandom_range(128, 239));
            else if (r < 82) b = 8'($urandom_range(248, 255));
            else             b = 8'($urandom_range(240, 247));
            send(b, ($urandom_range(0, 99) < 5) ? 1'b0 : 1'b1);
        end
        check_queues("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
